// File: rtl/inst_sram_axi_bridge_pkg.sv
// inst_sram_axi_bridge_pkg: AXI constants and AR state encoding shared by the fetch bridge
package inst_sram_axi_bridge_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  typedef enum logic {AR_IDLE = 1'b0, AR_WAIT = 1'b1} ar_state_e;
endpackage

// File: rtl/inst_sram_axi_bridge.sv
// inst_sram_axi_bridge: sram-like instruction fetch port to single-beat in-order AXI3 reads
// Define INST_BRIDGE_ERR_EN to enable the sticky bus_err flag.
module inst_sram_axi_bridge
  import inst_sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic [31:0] inst_sram_addr_ok_addr,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX = CW'(DEPTH);
  ar_state_e state;
  logic [CW-1:0] count;
  logic ar_hs, r_hs, unused;
  assign ar_hs = arvalid && arready;
  assign r_hs = rvalid && rready;
  assign rready = count != '0;
  assign inst_sram_addr_ok = ar_hs;
  assign inst_sram_addr_ok_addr = araddr;
  assign arlen = '0;
  assign arlock = '0;
  assign arcache = '0;
  assign arprot = '0;
  assign unused = ^{inst_sram_wen, inst_sram_wdata, rlast, rresp, rid};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= AR_IDLE;
      count <= '0;
      arvalid <= 1'b0;
      araddr <= '0;
      arsize <= '0;
      arid <= '0;
      arburst <= '0;
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata <= '0;
    end else begin
      arid <= AXI_ID;
      arburst <= AXI_BURST_INCR;
      count <= count + CW'(ar_hs) - CW'(r_hs);
      inst_sram_data_ok <= r_hs;
      if (r_hs) inst_sram_rdata <= rdata;
      if (state == AR_IDLE) begin
        if (inst_sram_en && !inst_sram_wr && count < MAX) begin
          araddr <= inst_sram_addr;
          arsize <= {1'b0, inst_sram_size};
          arvalid <= 1'b1;
          state <= AR_WAIT;
        end
      end else if (arready) begin
        arvalid <= 1'b0;
        state <= AR_IDLE;
      end
    end
  end
`ifdef INST_BRIDGE_ERR_EN
  // rdata is still forwarded on an erroring beat; only the flag records it
  always_ff @(posedge clk)
    bus_err <= !resetn ? 1'b0 : bus_err | (r_hs && (rresp != AXI_RESP_OKAY || rid != AXI_ID))
                                        | (inst_sram_en && inst_sram_wr);
`else
  assign bus_err = 1'b0;
`endif
endmodule
